// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    function automatic int depth_f(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo_param: synchronous write, asynchronous read, no reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = depth_f(ADDR_W);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: only accepted writes reach the array, so rejected ones never corrupt data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AFULL_TH  = depth_f(ADDR_W) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_afull,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [ADDR_W:0] AFULL_TH_C  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_TH_C = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wr_ptr_r;
    logic [ADDR_W:0]   rd_ptr_r;
    logic [ADDR_W:0]   count_s;
    logic              empty_s;
    logic              full_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              overflow_r;
    logic              underflow_r;
    logic [DATA_W-1:0] mem_rdata_s;

    // Occupancy and flags derive only from the registered pointers; wrap is plain rollover.
    assign count_s  = wr_ptr_r - rd_ptr_r;
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                      (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
    assign wr_acc_s = wr_en && !full_s;
    assign rd_acc_s = rd_en && !empty_s;

    // Pointer registers advance on accepted operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end
            if (rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end else if (err_clr) begin
                underflow_r <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s && !rst),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (mem_rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem_rdata_s;
    assign rd_valid = !empty_s;
`else
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // Registered read: capture the head word on an accepted pop, otherwise hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= mem_rdata_s;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
`endif

    assign count     = count_s;
    assign rd_empty  = empty_s;
    assign wr_full   = full_s;
    assign wr_afull  = (count_s >= AFULL_TH_C);
    assign rd_aempty = (count_s <= AEMPTY_TH_C);
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, ADDR_W=2, AFULL_TH=3, AEMPTY_TH=1).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       wr_full, wr_afull, rd_valid, rd_empty, rd_aempty, overflow, underflow;
    logic [7:0] rd_data;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .wr_afull(wr_afull), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_empty(rd_empty), .rd_aempty(rd_aempty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", rd_empty); end
        checks++; if (rd_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b want 1", rd_aempty); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", wr_full); end
        checks++; if (wr_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", wr_afull); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rd_data); end
`endif
    endtask

    task automatic test_reset_mid();
        pop();
        push(8'h01); push(8'h02); push(8'h03);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count got %0d want 3", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL rstmid_pre_uflow got %b want 1", underflow); end
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        rst = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", count); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b want 1", rd_empty); end
        checks++; if ({overflow, underflow, wr_afull, wr_full} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got %b%b%b%b want 0000", overflow, underflow, wr_afull, wr_full); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", rd_valid); end
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        push(8'h77);
        checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL fwft_head got %h want 77", rd_data); end
        checks++; if ({rd_valid, rd_empty} !== 2'b10) begin errors++; $display("FAIL fwft_valid got %b%b want 10", rd_valid, rd_empty); end
        step();
        checks++; if (count !== 3'd1 || rd_data !== 8'h77) begin errors++; $display("FAIL fwft_hold got %0d/%h want 1/77", count, rd_data); end
        pop();
        checks++; if ({rd_empty, rd_valid} !== 2'b10) begin errors++; $display("FAIL fwft_pop got %b%b want 10", rd_empty, rd_valid); end
        push(8'h12); push(8'h34);
        checks++; if (rd_data !== 8'h12) begin errors++; $display("FAIL fwft_order0 got %h want 12", rd_data); end
        pop();
        checks++; if (rd_data !== 8'h34) begin errors++; $display("FAIL fwft_order1 got %h want 34", rd_data); end
        pop();
    endtask
`else
    task automatic test_fill_drain();
        logic [7:0] vals  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [2:0] cnt_w [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [2:0] cnt_r [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        logic       af    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       fu    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       ae    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            push(vals[i]);
            checks++; if (count !== cnt_w[i]) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, cnt_w[i]); end
            checks++; if ({wr_afull, wr_full, rd_aempty, rd_empty} !== {af[i], fu[i], ae[i], 1'b0}) begin errors++; $display("FAIL fill_flags[%0d] got %b%b%b%b want %b%b%b0", i, wr_afull, wr_full, rd_aempty, rd_empty, af[i], fu[i], ae[i]); end
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (rd_data !== vals[i] || rd_valid !== 1'b1) begin errors++; $display("FAIL drain_data[%0d] got %h/%b want %h/1", i, rd_data, rd_valid, vals[i]); end
            checks++; if (count !== cnt_r[i]) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, cnt_r[i]); end
        end
        rd_en = 1'b0;
        step();
        checks++; if ({rd_valid, rd_empty} !== 2'b01) begin errors++; $display("FAIL drain_idle got %b%b want 01", rd_valid, rd_empty); end
        checks++; if (rd_data !== 8'h44) begin errors++; $display("FAIL drain_hold got %h want 44", rd_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) push(vals[i]);
        push(8'h55);
        checks++; if (count !== 3'd4 || wr_full !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d/%b want 4/1", count, wr_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        clear_err();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            pop();
            checks++; if (rd_data !== vals[i]) begin errors++; $display("FAIL ovf_contents[%0d] got %h want %h", i, rd_data, vals[i]); end
        end
    endtask

    task automatic test_underflow_wr();
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL uflow_count got %0d want 1", count); end
        checks++; if ({underflow, rd_valid} !== 2'b10) begin errors++; $display("FAIL uflow_flag got %b%b want 10", underflow, rd_valid); end
        pop();
        checks++; if (rd_data !== 8'hA5 || rd_valid !== 1'b1) begin errors++; $display("FAIL uflow_data got %h/%b want a5/1", rd_data, rd_valid); end
        clear_err();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uflow_clear got %b want 0", underflow); end
    endtask

    task automatic test_full_rw();
        logic [7:0] rest [3] = '{8'h22, 8'h33, 8'h44};
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h66;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL fullrw_state got %0d/%b want 3/1", count, overflow); end
        checks++; if (rd_data !== 8'h11 || rd_valid !== 1'b1) begin errors++; $display("FAIL fullrw_head got %h/%b want 11/1", rd_data, rd_valid); end
        for (int i = 0; i < 3; i++) begin
            pop();
            checks++; if (rd_data !== rest[i]) begin errors++; $display("FAIL fullrw_rest[%0d] got %h want %h", i, rd_data, rest[i]); end
        end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL fullrw_dropped got %b want 1", rd_empty); end
        clear_err();
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        push(8'h80); push(8'h81);
        rd_en = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'h82 + 8'(i);
            wr_data = d;
            step();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 2", i, count); end
            checks++; if (rd_data !== d - 8'h02) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, rd_data, d - 8'h02); end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        pop();
        checks++; if (rd_data !== 8'h8A) begin errors++; $display("FAIL wrap_tail0 got %h want 8a", rd_data); end
        pop();
        checks++; if (rd_data !== 8'h8B || rd_empty !== 1'b1) begin errors++; $display("FAIL wrap_tail1 got %h/%b want 8b/1", rd_data, rd_empty); end
    endtask
`endif

    initial begin
        step(); step();
        rst = 1'b0;
        test_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_fill_drain();
        test_overflow();
        test_underflow_wr();
        test_full_rw();
        test_wrap();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
